// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first pending index after the pointer.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   pend_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 found_o
);

  int   cand;
  logic hit;

  always_comb begin
    idx_o = '0;
    cand  = 0;
    hit   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // Explicit wrap keeps non-power-of-2 counts correct.
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!hit && pend_i[cand[IDX_WIDTH-1:0]]) begin
        hit   = 1'b1;
        idx_o = cand[IDX_WIDTH-1:0];
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port; one transaction outstanding at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_read_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]              req_resp_o,
  output logic [DATA_WIDTH-1:0]           req_rdata_o,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_resp,
  output logic                            busy_o
);

  arb_state_e             state_q, state_d;
  logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

  logic [NUM_REQ-1:0]     pending;
  logic [IDX_WIDTH-1:0]   pick_idx;
  logic                   pick_found;
  logic [ADDR_WIDTH-1:0]  addr_sel;
  logic [DATA_WIDTH-1:0]  wdata_sel;
  logic                   rd_sel, wr_sel;
  logic                   resp_hit;

  assign pending  = req_read_i | req_write_i;
  assign resp_hit = (state_q == ARB_BUSY) && mem_resp;

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .pend_i  (pending),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    rd_sel    = 1'b0;
    wr_sel    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_WIDTH'(i)) begin
        addr_sel  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_sel = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        rd_sel    = req_read_i[i];
        wr_sel    = req_write_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= IDX_WIDTH'(NUM_REQ - 1);
      gidx_q   <= '0;
      grant_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      read_q   <= read_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_found) state_d = ARB_BUSY;
      ARB_BUSY: if (mem_resp)   state_d = ARB_IDLE;
      default:                  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    read_d   = read_q;
    write_d  = write_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          grant_d = NUM_REQ'(idx_to_onehot(MAX_IDX_W'(pick_idx)));
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          // A requester asserting both strobes is treated as a write.
          write_d = wr_sel;
          read_d  = rd_sel & ~wr_sel;
          busy_d  = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (mem_resp) begin
          rr_ptr_d = gidx_q;
          grant_d  = '0;
          read_d   = 1'b0;
          write_d  = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign req_resp_o  = resp_hit ? grant_q : '0;
  assign req_rdata_o = resp_hit ? mem_rdata : '0;
  assign grant_o     = grant_q;
  assign mem_read    = read_q;
  assign mem_write   = write_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one memory port (mem_read/mem_write/mem_addr/mem_wdata/mem_resp/mem_rdata) among NUM_REQ requesters.
- Requesters are the rand_mem_write_module instances and their read counterparts. Each holds its read or write strobe high until it sees a response.
- Only one transaction is outstanding at a time. The grant is held from issue until mem_resp.

Parameters:
- NUM_REQ, 4: number of requesters; must be 2 to 16.
- ADDR_WIDTH, 64: memory address width.
- DATA_WIDTH, 64: memory data width.
- IDX_WIDTH, $clog2(NUM_REQ): width of the grant index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_read_i  in  NUM_REQ  per-requester read strobe, level, held until resp.
- req_write_i  in  NUM_REQ  per-requester write strobe, level, held until resp.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data, same packing as req_addr_i.
- req_resp_o  out  NUM_REQ  one-hot response pulse to the granted requester.
- req_rdata_o  out  DATA_WIDTH  read data broadcast to all requesters; valid with req_resp_o.
- grant_o  out  NUM_REQ  one-hot current owner; zero when idle.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_resp  in  1  memory completion, one-cycle pulse.
- busy_o  out  1  transaction outstanding.

Behaviour:
- States: IDLE, BUSY.
- Reset values:
  - state=IDLE.
  - rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0: grant_o, mem_read, mem_write, mem_addr, mem_wdata, busy_o, req_resp_o, req_rdata_o.
- A requester is pending when req_read_i[i] | req_write_i[i].
- IDLE, no requester pending: stay in IDLE; all mem strobes stay 0.
- IDLE, any requester pending: select the first pending index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. At that clock edge, register:
  - grant index and grant_o;
  - mem_addr and mem_wdata from that requester's slices;
  - mem_write = req_write_i[g];
  - mem_read = req_read_i[g] & ~req_write_i[g] (write wins if both are set);
  - busy_o=1; go to BUSY.
- Issue latency: strobe sampled at edge N, then mem_* valid in cycle N+1.
- All mem_* outputs come from flops and are stable for the whole of BUSY. Requester inputs are ignored during BUSY, including a requester dropping its strobe; the transaction still completes.
- BUSY, mem_resp=1 in a cycle:
  - req_resp_o[g]=1 and req_rdata_o=mem_rdata, combinationally in that same cycle (0 otherwise);
  - at that edge: mem_read, mem_write, grant_o, busy_o go to 0; rr_ptr<=g; state<=IDLE.
- The requester clears its strobe on the same edge as the response. IDLE therefore re-samples a clean request vector next cycle.
- Minimum spacing between back-to-back grants is one IDLE cycle.
- mem_resp arriving while IDLE is ignored: no req_resp_o pulse, no state change.
- Fairness: a requester that stays pending is granted within NUM_REQ transactions.
- If only one requester is pending, it is re-granted after each IDLE cycle.
- Reset mid-transaction: the outstanding access is abandoned. Outputs return to reset values on the next edge, and no response is delivered.
- Width rules:
  - rr_ptr+k wraps modulo NUM_REQ; non-power-of-2 NUM_REQ uses an explicit compare-and-subtract, never truncation.
  - req_rdata_o passes mem_rdata through unmodified.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum arb_state_e {ARB_IDLE, ARB_BUSY};
  - helper function idx_to_onehot.
- One sub-module rr_pick, purely combinational: pending vector and pointer in, grant index and found flag out.
- The FSM, output registers and packed-slice muxing stay in mem_port_arbiter.

Test Plan:
- Single write: req_write_i=4'b0100, addr slice 2=0x40, wdata=0xDEAD; mem_resp 3 cycles after issue. Required: mem_write=1, mem_addr=0x40, mem_wdata=0xDEAD one cycle after the request; req_resp_o=4'b0100 in the resp cycle; mem_write=0 the next cycle.
- Round-robin: all four requesters held pending, each with 1-cycle resp. Required: grant order 0,1,2,3,0; each grant_o one-hot; one IDLE cycle between grants.
- Read data: requester 1 reads with mem_rdata=0x1234 on resp. Required: req_rdata_o=0x1234 and req_resp_o=4'b0010 in the same cycle.
- Read and write both set by requester 3. Required: mem_write=1, mem_read=0.
- Requester drops its strobe mid-BUSY. Required: mem_* held until mem_resp; response pulse still delivered.
- Reset mid-BUSY. Required: all outputs 0 next cycle; the next grant goes to requester 0; a stray mem_resp in IDLE produces no req_resp_o.
